// File: rtl/expr_sequencer_if.sv
// Token load, control, shared-ALU and result bundle for expr_sequencer.
interface expr_sequencer_if #(
    parameter int RES_W = 8
);
    logic                    load_valid;
    logic                    load_ready;
    logic signed [3:0]       load_operand;
    logic [1:0]              load_op;
    logic                    mode;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic signed [RES_W-1:0] alu_a;
    logic signed [RES_W-1:0] alu_b;
    logic [1:0]              alu_op;
    logic                    alu_req;
    logic signed [RES_W-1:0] alu_y;
    logic signed [RES_W-1:0] result;
    logic                    flag_sign;
    logic                    flag_zero;
    logic                    flag_dz;

    modport slave (
        input  load_valid, load_operand, load_op, mode, start, alu_y,
        output load_ready, busy, done, alu_a, alu_b, alu_op, alu_req,
        output result, flag_sign, flag_zero, flag_dz
    );

    modport master (
        output load_valid, load_operand, load_op, mode, start, alu_y,
        input  load_ready, busy, done, alu_a, alu_b, alu_op, alu_req,
        input  result, flag_sign, flag_zero, flag_dz
    );
endinterface

// File: rtl/expr_sequencer.sv
// Five-token expression evaluator driving a shared external ALU,
// left-to-right or with mul/div folded first.
module expr_sequencer #(
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    expr_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {COLLECT, FULL, PASS1, PASS2, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t                  r_state, w_next;
    logic [2:0]              r_cnt;
    logic [1:0]              r_step;
    logic signed [RES_W-1:0] r_v [0:4];
    logic [1:0]              r_op [0:3];
    logic signed [RES_W-1:0] r_acc;
    logic signed [RES_W-1:0] r_result;
    logic                    r_sign, r_zero, r_dz, r_done;

    logic [2:0]              w_nidx;
    logic signed [RES_W-1:0] w_a, w_b, w_val;
    logic [1:0]              w_op;
    logic                    w_arith, w_dz, w_req, w_go;

    assign w_nidx = {1'b0, r_step} + 3'd1;
    assign w_go   = bus.start && (r_state == FULL || r_state == DONE);

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_op    = OP_ADD;
        w_arith = 1'b0;
        unique case (r_state)
            PASS1: begin
                w_a     = r_v[r_step];
                w_b     = r_v[w_nidx];
                w_op    = r_op[r_step];
                w_arith = r_op[r_step][1];
            end
            PASS2: begin
                w_a     = (r_step == 2'd0) ? r_v[0] : r_acc;
                w_b     = r_v[w_nidx];
                w_op    = r_op[r_step];
                w_arith = 1'b1;
            end
            default: ;
        endcase
    end

    // Divide by zero bypasses the ALU and yields 0.
    assign w_dz  = w_arith && (w_op == OP_DIV) && (w_b == '0);
    assign w_req = w_arith && !w_dz;
    assign w_val = w_req ? bus.alu_y : '0;

    assign bus.alu_req    = w_req;
    assign bus.alu_a      = w_req ? w_a : '0;
    assign bus.alu_b      = w_req ? w_b : '0;
    assign bus.alu_op     = w_req ? w_op : 2'b00;
    assign bus.load_ready = (r_state == COLLECT);
    assign bus.busy       = (r_state == PASS1) || (r_state == PASS2);
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.flag_sign  = r_sign;
    assign bus.flag_zero  = r_zero;
    assign bus.flag_dz    = r_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= COLLECT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            COLLECT: if (bus.load_valid && r_cnt == 3'd4) w_next = FULL;
            FULL:    if (w_go) w_next = bus.mode ? PASS1 : PASS2;
            PASS1:   if (r_step == 2'd3) w_next = PASS2;
            PASS2:   if (r_step == 2'd3) w_next = DONE;
            DONE: begin
                if (w_go)                w_next = bus.mode ? PASS1 : PASS2;
                else if (bus.load_valid) w_next = COLLECT;
            end
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_step   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < 5; i++) r_v[i] <= '0;
            for (int i = 0; i < 4; i++) r_op[i] <= OP_ADD;
        end else begin
            r_done <= 1'b0;
            if (w_go) begin
                r_dz   <= 1'b0;
                r_step <= '0;
            end
            unique case (r_state)
                COLLECT: if (bus.load_valid) begin
                    r_v[r_cnt] <= {{(RES_W-4){bus.load_operand[3]}},
                                   bus.load_operand};
                    if (r_cnt != 3'd4) r_op[r_cnt[1:0]] <= bus.load_op;
                    r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
                end
                PASS1: begin
                    // Fold v[i] into v[i+1]; the zeroed slot inherits
                    // the preceding operator so the sum is unchanged.
                    if (w_arith) begin
                        r_v[w_nidx]  <= w_val;
                        r_v[r_step]  <= '0;
                        r_op[r_step] <= (r_step == 2'd0) ? OP_ADD
                                        : r_op[r_step - 2'd1];
                    end
                    if (w_dz) r_dz <= 1'b1;
                    r_step <= r_step + 2'd1;
                end
                PASS2: begin
                    r_acc <= w_val;
                    if (w_dz) r_dz <= 1'b1;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_result <= w_val;
                        r_sign   <= w_val[RES_W-1];
                        r_zero   <= (w_val == '0);
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_expr_sequencer.sv
// Directed self-checking bench for expr_sequencer with a behavioural ALU.
module tb_expr_sequencer;
    localparam int RES_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    expr_sequencer_if #(.RES_W(RES_W)) bus ();

    expr_sequencer #(.RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.alu_y = '0;
        case (bus.alu_op)
            2'b00: bus.alu_y = bus.alu_a + bus.alu_b;
            2'b01: bus.alu_y = bus.alu_a - bus.alu_b;
            2'b10: bus.alu_y = bus.alu_a * bus.alu_b;
            2'b11: bus.alu_y = (bus.alu_b == 0) ? '0 : bus.alu_a / bus.alu_b;
            default: ;
        endcase
    end

    task automatic send_tok(input int val, input int op);
        logic [31:0] v = val;
        logic [31:0] o = op;
        @(negedge clk);
        bus.load_valid   = 1'b1;
        bus.load_operand = v[3:0];
        bus.load_op      = o[1:0];
    endtask

    task automatic end_load();
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic leave_done();
        @(negedge clk);
        bus.load_valid   = 1'b1;
        bus.load_operand = 4'sd5;
        bus.load_op      = 2'b10;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic run_eval(input logic m, output int lat,
                            output logic [31:0] reqs, output logic viol,
                            output logic busy1);
        reqs  = '0;
        viol  = 1'b0;
        busy1 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = ~m;
        lat   = 1;
        busy1 = bus.busy;
        while (bus.done !== 1'b1 && lat < 30) begin
            reqs[lat] = bus.alu_req;
            if (bus.alu_req === 1'b0 &&
                (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== 2'b00))
                viol = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int elat,
                                input int eres, input logic es, input logic ez,
                                input logic edz);
        logic signed [RES_W-1:0] r = eres[RES_W-1:0];
        n_checks++;
        if (lat !== elat) begin
            n_errors++;
            $display("FAIL %s_latency got %0d want %0d", tag, lat, elat);
        end
        n_checks++;
        if (bus.result !== r) begin
            n_errors++;
            $display("FAIL %s_result got %0d want %0d", tag, $signed(bus.result), eres);
        end
        n_checks++;
        if ({bus.flag_sign, bus.flag_zero, bus.flag_dz} !== {es, ez, edz}) begin
            n_errors++;
            $display("FAIL %s_flags got %b%b%b want %b%b%b", tag, bus.flag_sign,
                     bus.flag_zero, bus.flag_dz, es, ez, edz);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", tag,
                     bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.load_ready, bus.busy, bus.done, bus.alu_req} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b want 1000",
                     {bus.load_ready, bus.busy, bus.done, bus.alu_req});
        end
        n_checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_alu got %h %h %b want 0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        n_checks++;
        if (bus.result !== '0 || {bus.flag_sign, bus.flag_zero, bus.flag_dz} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_result got %h %b%b%b want 0 000", bus.result,
                     bus.flag_sign, bus.flag_zero, bus.flag_dz);
        end
        rst = 1'b0;
    endtask

    task automatic test_collect_full();
        send_tok(3, 0);
        send_tok(2, 2);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL start_in_collect got busy=%b ready=%b want 0 1",
                     bus.busy, bus.load_ready);
        end
        send_tok(3, 1);
        send_tok(1, 3);
        send_tok(2, 0);
        end_load();
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready got %b want 0", bus.load_ready);
        end
        @(negedge clk);
        bus.load_valid   = 1'b1;
        bus.load_operand = 4'sd7;
        bus.load_op      = 2'b10;
        @(negedge clk);
        bus.load_valid = 1'b0;
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready_offer got %b want 0", bus.load_ready);
        end
    endtask

    task automatic test_left_to_right();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("ltr", lat, 5, 7, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (b1 !== 1'b1 || reqs[4:1] !== 4'b1111 || viol !== 1'b0) begin
            n_errors++;
            $display("FAIL ltr_alu got busy=%b req=%b viol=%b want 1 1111 0",
                     b1, reqs[4:1], viol);
        end
    endtask

    task automatic test_precedence();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        run_eval(1'b1, lat, reqs, viol, b1);
        check_result("prec", lat, 9, 9, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (reqs[8:1] !== 8'b1111_1010 || viol !== 1'b0) begin
            n_errors++;
            $display("FAIL prec_alu_req got %b viol=%b want 11111010 0", reqs[8:1], viol);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        leave_done();
        n_checks++;
        if (bus.load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL done_to_collect got ready=%b want 1", bus.load_ready);
        end
        send_tok(2, 3);
        send_tok(0, 0);
        send_tok(1, 0);
        send_tok(1, 0);
        send_tok(1, 0);
        end_load();
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("dz", lat, 5, 3, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (reqs[4:1] !== 4'b1110 || viol !== 1'b0) begin
            n_errors++;
            $display("FAIL dz_alu_req got %b viol=%b want 1110 0", reqs[4:1], viol);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("rerun", lat, 5, 3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_pass();
        int dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.load_ready, bus.busy, bus.done, bus.alu_req} !== 4'b1000) begin
            n_errors++;
            $display("FAIL midrst_ctrl got %b want 1000",
                     {bus.load_ready, bus.busy, bus.done, bus.alu_req});
        end
        n_checks++;
        if (bus.result !== '0 || {bus.flag_sign, bus.flag_zero, bus.flag_dz} !== 3'b000 ||
            bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== 2'b00) begin
            n_errors++;
            $display("FAIL midrst_data got res=%h flags=%b%b%b want 0 000", bus.result,
                     bus.flag_sign, bus.flag_zero, bus.flag_dz);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++;
            $display("FAIL midrst_no_done got %0d activity cycles want 0", dones);
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        send_tok(-8, 2);
        send_tok(7, 2);
        send_tok(7, 0);
        send_tok(1, 1);
        send_tok(1, 0);
        end_load();
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("wrap", lat, 5, 120, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        leave_done();
        send_tok(1, 1);
        send_tok(1, 0);
        send_tok(0, 0);
        send_tok(0, 0);
        send_tok(0, 0);
        end_load();
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("zero", lat, 5, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sign();
        int lat;
        logic [31:0] reqs;
        logic viol, b1;
        leave_done();
        send_tok(1, 1);
        send_tok(7, 0);
        send_tok(0, 0);
        send_tok(0, 0);
        send_tok(0, 0);
        end_load();
        run_eval(1'b0, lat, reqs, viol, b1);
        check_result("sign", lat, 5, -6, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.load_valid   = 1'b0;
        bus.load_operand = '0;
        bus.load_op      = '0;
        bus.mode         = 1'b0;
        bus.start        = 1'b0;
        test_reset();
        test_collect_full();
        test_left_to_right();
        test_precedence();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_pass();
        test_wrap();
        test_zero();
        test_sign();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
